// File: rtl/cpu_bus_responder_pkg.sv
// cpu_bus_responder_pkg: shared FSM states and address-map constants for the CPU bus responder
package cpu_bus_responder_pkg;
   typedef enum logic [1:0] {IDLE, RAM_RD, PRG_WAIT, DONE} state_t;
   localparam logic [15:0] RAM_TOP       = 16'h1FFF;
   localparam logic [15:0] PRG_BASE      = 16'h8000;
   localparam logic [7:0]  OPEN_BUS_FILL = 8'hFF;
   function automatic logic is_ram(input logic [15:0] a);
      return a <= RAM_TOP;
   endfunction
   function automatic logic is_prg(input logic [15:0] a);
      return a >= PRG_BASE;
   endfunction
endpackage

// File: rtl/cpu_ram.sv
// cpu_ram: single-port RAM with one write port and a registered read port, contents survive reset
module cpu_ram #(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);
   logic [7:0] mem_q [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
      if (re) rdata <= mem_q[addr];
   end
endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: CPU bus slave decoding mirrored RAM, wait-stated PRG-ROM reads with timeout, and open bus
module cpu_bus_responder
   import cpu_bus_responder_pkg::*;
#(
   parameter int PRG_TIMEOUT = 15,
   parameter int RAM_AW      = 11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic        write,
   input  logic [7:0]  d_out,
   output logic [7:0]  d_in,
   output logic        ready,
   output logic        prg_req,
   output logic [14:0] prg_addr,
   input  logic        prg_ack,
   input  logic [7:0]  prg_data,
   output logic        bus_err
);
   localparam int CW = $clog2(PRG_TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(PRG_TIMEOUT);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [7:0] rdata_q, rdata_d, open_bus_q, open_bus_d, ram_rdata;
   logic err_q, err_d, req, ram_we, ram_re;

   cpu_ram #(.AW(RAM_AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (addr[RAM_AW-1:0]),
      .wdata (d_out),
      .rdata (ram_rdata)
   );

   assign cnt_inc  = cnt_q + CW'(1);
   assign prg_addr = addr[14:0];
   assign prg_req  = req & ~reset;
   assign bus_err  = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      ready   = 1'b0;
      d_in    = open_bus_q;
      req     = 1'b0;
      ram_we  = 1'b0;
      ram_re  = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_ram(addr)) begin
               ready   = write;
               ram_we  = write;
               ram_re  = ~write;
               state_d = write ? IDLE : RAM_RD;
            end else if (is_prg(addr) && !write) begin
               req     = 1'b1;
               cnt_d   = '0;
               state_d = PRG_WAIT;
            end else begin
               ready = 1'b1;
            end
         end
         RAM_RD: begin
            ready   = 1'b1;
            d_in    = ram_rdata;
            state_d = IDLE;
         end
         PRG_WAIT: begin
            req   = 1'b1;
            cnt_d = cnt_inc;
            // an ack on the final cycle still wins over the timeout
            if (prg_ack) begin
               rdata_d = prg_data;
               state_d = DONE;
            end else if (cnt_inc == TMO) begin
               rdata_d = OPEN_BUS_FILL;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            ready   = 1'b1;
            d_in    = rdata_q;
            state_d = IDLE;
         end
      endcase
      open_bus_d = ready ? (write ? d_out : d_in) : open_bus_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rdata_q    <= 8'h00;
         open_bus_q <= 8'h00;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         open_bus_q <= open_bus_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed-vector bench for cpu_bus_responder with hand-computed expectations
module tb_cpu_bus_responder;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] addr;
   logic        write;
   logic [7:0]  d_out;
   logic [7:0]  d_in;
   logic        ready;
   logic        prg_req;
   logic [14:0] prg_addr;
   logic        prg_ack;
   logic [7:0]  prg_data;
   logic        bus_err;
   int          n_chk = 0;
   int          n_pass = 0;

   cpu_bus_responder #(.PRG_TIMEOUT(15), .RAM_AW(11)) dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .write    (write),
      .d_out    (d_out),
      .d_in     (d_in),
      .ready    (ready),
      .prg_req  (prg_req),
      .prg_addr (prg_addr),
      .prg_ack  (prg_ack),
      .prg_data (prg_data),
      .bus_err  (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d);
      addr  = a;
      write = w;
      d_out = d;
      #1;
   endtask

   task automatic run_prg(input logic [15:0] a, input int ack_at, input logic [7:0] data,
                          output int lows, output logic [7:0] rd);
      lows     = 0;
      rd       = 8'hXX;
      prg_data = data;
      for (int k = 0; k < 64; k++) begin
         addr    = a;
         write   = 1'b0;
         prg_ack = (k == ack_at);
         #1;
         if (ready) begin
            rd = d_in;
            break;
         end
         if (k == 0) begin
            chk("prg_req_start", 16'(prg_req), 16'h1);
            chk("prg_addr", 16'(prg_addr), {1'b0, a[14:0]});
         end
         lows++;
         next_cyc();
      end
      prg_ack = 1'b0;
   endtask

   initial begin
      int         lows;
      logic [7:0] rd;
      reset = 1'b1; addr = 16'h4000; write = 1'b0; d_out = 8'h00;
      prg_ack = 1'b0; prg_data = 8'h00;
      #2;
      chk("rst_prg_req", 16'(prg_req), 16'h0);
      chk("rst_bus_err", 16'(bus_err), 16'h0);
      chk("rst_ready", 16'(ready), 16'h1);
      chk("rst_open_bus", 16'(d_in), 16'h00);
      next_cyc(); next_cyc();
      reset = 1'b0;
      // RAM write then mirrored read
      bus(16'h0123, 1'b1, 8'h5A);
      chk("ram_wr_ready", 16'(ready), 16'h1);
      next_cyc();
      bus(16'h0923, 1'b0, 8'h00);
      chk("ram_rd_wait", 16'(ready), 16'h0);
      chk("ram_rd_wait_openbus", 16'(d_in), 16'h5A);
      next_cyc();
      #1;
      chk("ram_rd_ready", 16'(ready), 16'h1);
      chk("ram_rd_mirror", 16'(d_in), 16'h5A);
      next_cyc();
      // unmapped write then unmapped read returns open bus
      bus(16'h4000, 1'b1, 8'h3C);
      chk("unm_wr_ready", 16'(ready), 16'h1);
      next_cyc();
      bus(16'h5000, 1'b0, 8'h00);
      chk("unm_rd_ready", 16'(ready), 16'h1);
      chk("unm_rd_openbus", 16'(d_in), 16'h3C);
      next_cyc();
      bus(16'h8000, 1'b1, 8'h66);
      chk("prg_wr_ready", 16'(ready), 16'h1);
      chk("prg_wr_no_req", 16'(prg_req), 16'h0);
      next_cyc();
      bus(16'h4000, 1'b0, 8'h00);
      chk("prg_wr_openbus", 16'(d_in), 16'h66);
      next_cyc();
      // PRG read acked on the fourth low cycle
      run_prg(16'h8000, 3, 8'hA9, lows, rd);
      chk("prg_ack_lows", 16'(lows), 16'd4);
      chk("prg_ack_data", 16'(rd), 16'hA9);
      chk("prg_ack_err", 16'(bus_err), 16'h0);
      next_cyc();
      prg_ack = 1'b1; prg_data = 8'h11;
      bus(16'h6000, 1'b0, 8'h00);
      chk("stray_ack_ready", 16'(ready), 16'h1);
      chk("stray_ack_ignored", 16'(d_in), 16'hA9);
      prg_ack = 1'b0;
      next_cyc();
      // ack on the very last cycle before timeout
      run_prg(16'h8001, 15, 8'h77, lows, rd);
      chk("edge_lows", 16'(lows), 16'd16);
      chk("edge_data", 16'(rd), 16'h77);
      chk("edge_err", 16'(bus_err), 16'h0);
      next_cyc();
      // no ack: timeout
      run_prg(16'hFFFC, -1, 8'h00, lows, rd);
      chk("tmo_lows", 16'(lows), 16'd16);
      chk("tmo_data", 16'(rd), 16'hFF);
      chk("tmo_err", 16'(bus_err), 16'h1);
      next_cyc();
      bus(16'h0123, 1'b0, 8'h00);
      next_cyc();
      #1;
      chk("tmo_after_ram", 16'(d_in), 16'h5A);
      chk("tmo_err_sticky", 16'(bus_err), 16'h1);
      next_cyc();
      // reset mid PRG_WAIT, then a late ack
      run_prg(16'h8000, -1, 8'h00, lows, rd);
      chk("tmo2_err", 16'(bus_err), 16'h1);
      next_cyc();
      bus(16'h8000, 1'b0, 8'h00);
      next_cyc();
      next_cyc();
      #1;
      chk("pre_rst_req", 16'(prg_req), 16'h1);
      reset = 1'b1;
      #1;
      chk("mid_rst_req", 16'(prg_req), 16'h0);
      chk("mid_rst_err", 16'(bus_err), 16'h0);
      addr = 16'h4000;
      prg_ack = 1'b1; prg_data = 8'h99;
      next_cyc();
      reset = 1'b0;
      #1;
      chk("late_ack_ready", 16'(ready), 16'h1);
      chk("late_ack_openbus", 16'(d_in), 16'h00);
      chk("late_ack_req", 16'(prg_req), 16'h0);
      next_cyc();
      prg_ack = 1'b0;
      bus(16'h1123, 1'b0, 8'h00);
      next_cyc();
      #1;
      chk("ram_kept", 16'(d_in), 16'h5A);
      chk("ram_kept_err", 16'(bus_err), 16'h0);
      next_cyc();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 Parameter PRG_TIMEOUT, default 15, SHALL set the maximum number of PRG_WAIT cycles before a PRG read is aborted.
REQ-002 Parameter RAM_AW, default 11, SHALL set the internal RAM address width (2 KiB).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 addr  input  16  SHALL be the CPU bus address, held stable by the CPU while ready=0.
REQ-006 write  input  1  SHALL be the CPU write strobe (1=write, 0=read), held with addr.
REQ-007 d_out  input  8  SHALL be the CPU write data.
REQ-008 d_in  output  8  SHALL be the read data returned to the CPU, valid when ready=1.
REQ-009 ready  output  1  SHALL be 0 to stall the CPU (wait state) and 1 when the current bus cycle completes.
REQ-010 prg_req  output  1  SHALL request a PRG-ROM read from the external memory port.
REQ-011 prg_addr  output  15  SHALL carry addr[14:0] while prg_req=1.
REQ-012 prg_ack  input  1  SHALL indicate prg_data is valid for the outstanding request.
REQ-013 prg_data  input  8  SHALL be the PRG-ROM read data, sampled when prg_ack=1.
REQ-014 bus_err  output  1  SHALL be a sticky flag set on any PRG timeout.

Function
REQ-015 Decode SHALL be: RAM = addr 0x0000-0x1FFF (mirrored on addr[10:0]); PRG = addr[15]=1; all else unmapped.
REQ-016 FSM states SHALL be IDLE, RAM_RD, PRG_WAIT, DONE.
REQ-017 IDLE, RAM write: ready=1, RAM[addr[10:0]] <= d_out at the clock edge, remain IDLE (zero wait states).
REQ-018 IDLE, RAM read: ready=0, RAM read issued, go RAM_RD; RAM_RD: ready=1, d_in=RAM output, go IDLE (exactly one wait state).
REQ-019 IDLE, PRG read: ready=0, prg_req=1, timeout counter cleared, go PRG_WAIT.
REQ-020 PRG_WAIT: ready=0, prg_req=1, counter +1 per cycle; on prg_ack=1 latch prg_data into rdata, go DONE.
REQ-021 PRG_WAIT with counter = PRG_TIMEOUT and prg_ack=0: rdata <= 0xFF, bus_err <= 1, go DONE.
REQ-022 Simultaneous prg_ack and timeout SHALL resolve as a successful ack (no error, prg_data returned).
REQ-023 DONE: ready=1, prg_req=0, d_in=rdata, go IDLE; prg_ack in any state other than PRG_WAIT SHALL be ignored.
REQ-024 PRG write and unmapped write: ready=1, no state change except open-bus update, remain IDLE.
REQ-025 Unmapped read: ready=1, d_in=open_bus, remain IDLE.
REQ-026 open_bus register SHALL capture d_out on every completed write and d_in on every completed read.
REQ-027 d_in SHALL equal open_bus whenever ready=0.
REQ-028 Counter SHALL be wide enough to hold PRG_TIMEOUT without wrap.
REQ-029 Back-to-back cycles SHALL be supported: a new request is decoded in the IDLE cycle immediately after RAM_RD or DONE.

Reset
REQ-030 Reset SHALL force state=IDLE, prg_req=0, counter=0, rdata=0x00, open_bus=0x00, bus_err=0.
REQ-031 Reset asserted mid-operation SHALL abandon the bus cycle immediately with prg_req dropping asynchronously; a late prg_ack SHALL be ignored.
REQ-032 RAM contents SHALL NOT be cleared by reset.
REQ-033 After reset, ready and d_in SHALL follow the IDLE decode of the current addr/write.

Structure
REQ-034 The state enum and decode region constants (RAM_TOP=0x1FFF, PRG_BASE=0x8000, OPEN_BUS_FILL=0xFF) SHALL live in the shared CPU package.
REQ-035 The 2 KiB synchronous-read RAM SHALL be a sub-module named cpu_ram (one write port, one registered read port).

Verification
REQ-036 Write 0x5A to 0x0123, then read 0x0923 -> ready low one cycle, then d_in=0x5A (mirror).
REQ-037 Read 0x8000 with prg_ack after 3 cycles, prg_data=0xA9 -> prg_addr=0x0000, ready low 4 cycles, then d_in=0xA9, bus_err=0.
REQ-038 Read 0xFFFC with prg_ack never asserted -> ready low PRG_TIMEOUT+1 cycles, d_in=0xFF, bus_err=1 until reset.
REQ-039 Write 0x3C to 0x4000 then read 0x5000 -> both zero-wait, read returns 0x3C (open bus).
REQ-040 Assert reset during PRG_WAIT, then ack -> prg_req=0 immediately, state IDLE, bus_err=0, ack ignored.
REQ-041 prg_ack coinciding with final timeout cycle, prg_data=0x77 -> d_in=0x77, bus_err=0.
